// File: rtl/pet_mood_fsm.sv
// pet_mood_fsm
//   Mood/state engine of the virtual pet. Tracks hunger, happiness and energy.
//   Reacts to debounced user buttons and to a periodic time tick. Drives the 2-bit
//   face code for the LED-matrix renderer (00 happy, 01 sad, 10 angry, 11 sleeping).
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_feed     one-cycle pulse, lowers hunger by FEED_AMT
//   btn_play     one-cycle pulse, raises happiness by PLAY_AMT, costs 1 energy
//   btn_sleep    one-cycle pulse, sends the pet to sleep
//   test_mode    1: tick period is TEST_DIV cycles, 0: TICK_DIV cycles
//   face         face code; this is the mood state register itself
//   hunger       0..STAT_MAX
//   happiness    0..STAT_MAX
//   energy       0..STAT_MAX
//   face_changed one-cycle pulse in the first cycle that face shows a new value

module pet_mood_fsm #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int TEST_DIV    = 50,
    parameter int DECAY_TICKS = 5,
    parameter int STAT_MAX    = 10,
    parameter int ANGRY_TH    = 8,
    parameter int SAD_TH      = 3,
    parameter int FEED_AMT    = 3,
    parameter int PLAY_AMT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_feed,
    input  logic       btn_play,
    input  logic       btn_sleep,
    input  logic       test_mode,
    output logic [1:0] face,
    output logic [3:0] hunger,
    output logic [3:0] happiness,
    output logic [3:0] energy,
    output logic       face_changed
);

    typedef enum logic [1:0] {
        HAPPY = 2'b00,
        SAD   = 2'b01,
        ANGRY = 2'b10,
        SLEEP = 2'b11
    } mood_t;

    mood_t       state;
    mood_t       next_state;
    logic [31:0] tick_cnt;
    logic [31:0] div_now;
    logic        test_mode_q;
    logic [3:0]  decay_cnt;
    logic        tick;
    logic        decay_now;
    logic signed [5:0] d_hunger;
    logic signed [5:0] d_happiness;
    logic signed [5:0] d_energy;

    // Deltas are summed in 6-bit signed so that underflow below zero is visible
    // before clamping back into the 0..STAT_MAX range.
    function automatic logic [3:0] clamp_stat(input logic signed [5:0] v);
        if (v < 6'sd0)
            return 4'd0;
        else if (v > 6'(STAT_MAX))
            return 4'(STAT_MAX);
        else
            return v[3:0];
    endfunction

    // Awake mood from the current stats: anger dominates sadness.
    function automatic mood_t awake_mood(input logic [3:0] h, input logic [3:0] p);
        if (h >= 4'(ANGRY_TH))
            return ANGRY;
        else if (p <= 4'(SAD_TH))
            return SAD;
        else
            return HAPPY;
    endfunction

    assign face = state;

    // A change of test_mode suppresses the tick for that cycle and restarts the count.
    always_comb begin
        div_now   = test_mode ? 32'(TEST_DIV) : 32'(TICK_DIV);
        tick      = (test_mode == test_mode_q) && (tick_cnt == div_now - 32'd1);
        decay_now = (state != SLEEP) && tick && (decay_cnt == 4'(DECAY_TICKS - 1));
    end

    // Stat deltas for this cycle. Sleep button outranks feed, feed outranks play;
    // decay still lands in the same update as any button.
    always_comb begin
        d_hunger    = 6'sd0;
        d_happiness = 6'sd0;
        d_energy    = 6'sd0;
        if (state != SLEEP) begin
            if (decay_now) begin
                d_hunger    = 6'sd1;
                d_happiness = -6'sd1;
                d_energy    = -6'sd1;
            end
            if (!btn_sleep) begin
                if (btn_feed) begin
                    d_hunger = d_hunger - 6'(FEED_AMT);
                end else if (btn_play) begin
                    d_happiness = d_happiness + 6'(PLAY_AMT);
                    d_energy    = d_energy - 6'sd1;
                end
            end
        end else if (tick) begin
            d_energy = 6'sd1;
        end
    end

    // Mood decision looks at the registered stats, so face trails stats by a cycle.
    always_comb begin
        next_state = state;
        if (state != SLEEP) begin
            if (btn_sleep || energy == 4'd0)
                next_state = SLEEP;
            else
                next_state = awake_mood(hunger, happiness);
        end else if (energy == 4'(STAT_MAX)) begin
            next_state = awake_mood(hunger, happiness);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HAPPY;
            hunger       <= 4'd0;
            happiness    <= 4'(STAT_MAX);
            energy       <= 4'(STAT_MAX);
            face_changed <= 1'b0;
            tick_cnt     <= 32'd0;
            decay_cnt    <= 4'd0;
            test_mode_q  <= test_mode;
        end else begin
            test_mode_q <= test_mode;
            if (test_mode != test_mode_q || tick)
                tick_cnt <= 32'd0;
            else
                tick_cnt <= tick_cnt + 32'd1;

            if (state == SLEEP)
                decay_cnt <= 4'd0;
            else if (tick)
                decay_cnt <= decay_now ? 4'd0 : decay_cnt + 4'd1;

            hunger       <= clamp_stat($signed({2'b00, hunger}) + d_hunger);
            happiness    <= clamp_stat($signed({2'b00, happiness}) + d_happiness);
            energy       <= clamp_stat($signed({2'b00, energy}) + d_energy);
            state        <= next_state;
            face_changed <= (next_state != state);
        end
    end

endmodule

// File: tb/tb_pet_mood_fsm.sv
// tb_pet_mood_fsm
//   Self-checking bench for pet_mood_fsm. A behavioural pet model runs on every
//   clock edge and pushes the expected output snapshot into a queue, plus the
//   expected new face whenever the mood changes. A monitor on the falling edge
//   pops and compares. Directed scenarios also check fixed values directly.
//
// Ports: none (top-level bench).

module tb_pet_mood_fsm;

    localparam int TB_TICK  = 120;
    localparam int TEST_DIV = 50;
    localparam int DECAY    = 5;
    localparam int SMAX     = 10;
    localparam int ANGRY_TH = 8;
    localparam int SAD_TH   = 3;
    localparam int FEED     = 3;
    localparam int PLAY     = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_feed, btn_play, btn_sleep, test_mode;
    logic [1:0] face;
    logic [3:0] hunger, happiness, energy;
    logic       face_changed;

    int total = 0;
    int bad   = 0;

    pet_mood_fsm #(.TICK_DIV(TB_TICK)) dut (
        .clk(clk), .reset(reset),
        .btn_feed(btn_feed), .btn_play(btn_play), .btn_sleep(btn_sleep),
        .test_mode(test_mode),
        .face(face), .hunger(hunger), .happiness(happiness), .energy(energy),
        .face_changed(face_changed)
    );

    always #5 clk = ~clk;

    // Reference pet, plain integers.
    int m_h, m_p, m_e, m_mood, m_fc, m_ticks_since_decay, m_cycle_in_period, m_prev_tm;
    logic [14:0] snap_q[$];
    logic [1:0]  face_q[$];

    function automatic int limit(input int v);
        return (v < 0) ? 0 : ((v > SMAX) ? SMAX : v);
    endfunction

    function automatic int mood_of(input int h, input int p);
        if (h >= ANGRY_TH) return 2;
        if (p <= SAD_TH)   return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        int  period, new_mood, nh, np, ne;
        bit  ticked;
        if (reset) begin
            m_h = 0; m_p = SMAX; m_e = SMAX; m_mood = 0; m_fc = 0;
            m_ticks_since_decay = 0; m_cycle_in_period = 0; m_prev_tm = int'(test_mode);
        end else begin
            period = test_mode ? TEST_DIV : TB_TICK;
            ticked = (int'(test_mode) == m_prev_tm) && (m_cycle_in_period == period - 1);
            if (int'(test_mode) != m_prev_tm || ticked) m_cycle_in_period = 0;
            else                                         m_cycle_in_period++;
            m_prev_tm = int'(test_mode);
            nh = m_h; np = m_p; ne = m_e;
            if (m_mood != 3) begin
                if (ticked) begin
                    m_ticks_since_decay++;
                    if (m_ticks_since_decay == DECAY) begin
                        nh += 1; np -= 1; ne -= 1;
                        m_ticks_since_decay = 0;
                    end
                end
                if (!btn_sleep && btn_feed)      nh -= FEED;
                else if (!btn_sleep && btn_play) begin np += PLAY; ne -= 1; end
                new_mood = (btn_sleep || m_e == 0) ? 3 : mood_of(m_h, m_p);
            end else begin
                m_ticks_since_decay = 0;
                if (ticked) ne += 1;
                new_mood = (m_e == SMAX) ? mood_of(m_h, m_p) : 3;
            end
            m_fc = (new_mood != m_mood) ? 1 : 0;
            m_mood = new_mood;
            m_h = limit(nh); m_p = limit(np); m_e = limit(ne);
            if (m_fc == 1) face_q.push_back(2'(m_mood));
        end
        snap_q.push_back({1'(m_fc), 2'(m_mood), 4'(m_h), 4'(m_p), 4'(m_e)});
    end

    // Monitor: compares every presented output snapshot and every face change.
    always @(negedge clk) begin
        logic [14:0] exp_s, got_s;
        logic [1:0]  exp_f;
        if (snap_q.size() > 0) begin
            exp_s = snap_q.pop_front();
            got_s = {face_changed, face, hunger, happiness, energy};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("[TB] FAIL snapshot t=%0t {fc,face,h,p,e} got=%h exp=%h", $time, got_s, exp_s);
            end
        end
        if (face_changed === 1'b1) begin
            total++;
            if (face_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL face_change_unexpected t=%0t got face=%b exp no change", $time, face);
            end else begin
                exp_f = face_q.pop_front();
                if (face !== exp_f) begin
                    bad++;
                    $display("[TB] FAIL face_change_value t=%0t got=%b exp=%b", $time, face, exp_f);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f, input logic p, input logic s);
        @(posedge clk); #1;
        btn_feed = f; btn_play = p; btn_sleep = s;
        @(posedge clk); #1;
        btn_feed = 1'b0; btn_play = 1'b0; btn_sleep = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] ef, input logic [3:0] eh,
                               input logic [3:0] ep, input logic [3:0] ee);
        @(negedge clk);
        total++;
        if (face !== ef || hunger !== eh || happiness !== ep || energy !== ee) begin
            bad++;
            $display("[TB] FAIL %s got face=%b h=%0d p=%0d e=%0d exp face=%b h=%0d p=%0d e=%0d",
                     name, face, hunger, happiness, energy, ef, eh, ep, ee);
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btn_feed = 1'b0; btn_play = 1'b0; btn_sleep = 1'b0; test_mode = 1'b1;
        waitCycles(3);
        checkOutput("reset_values", 2'b00, 4'd0, 4'd10, 4'd10);
        reset = 1'b0;

        // Five ticks of 50 cycles: one decay step.
        waitCycles(253);
        checkOutput("five_ticks", 2'b00, 4'd1, 4'd9, 4'd9);

        // Forty ticks total: eight decays, hunger wins over sadness.
        waitCycles(2010 - 253);
        checkOutput("forty_ticks_angry", 2'b10, 4'd8, 4'd2, 4'd2);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("feed_to_sad", 2'b01, 4'd5, 4'd2, 4'd2);

        // Two plays drain the last energy; the pet falls asleep and recharges.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitCycles(650);

        // Awake pet put to sleep by button, buttons ignored while asleep.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(200);

        // Feed+play together at hunger 1: feed wins and clamps at zero.
        doReset();
        waitCycles(253);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("feed_play_clamp", 2'b00, 4'd0, 4'd9, 4'd9);

        // Reset while asleep.
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCycles(20);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("reset_mid_sleep", 2'b00, 4'd0, 4'd10, 4'd10);
        reset = 1'b0;

        // Normal-mode tick period, with a mode change part way through.
        test_mode = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk); #1;
            btn_feed  = ($urandom_range(0, 59) == 0);
            btn_play  = ($urandom_range(0, 59) == 0);
            btn_sleep = 1'b0;
            if (i == 700) test_mode = 1'b1;
            if (i == 760) test_mode = 1'b0;
        end

        // Random buttons, mode flips and occasional resets.
        test_mode = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            int r;
            @(posedge clk); #1;
            r = int'($urandom_range(0, 99));
            btn_feed  = (r < 4) || (r >= 8 && r < 10);
            btn_play  = (r >= 4 && r < 8) || (r >= 8 && r < 11);
            btn_sleep = (r == 11) || (r == 9);
            if ($urandom_range(0, 399) == 0) test_mode = ~test_mode;
            reset = ($urandom_range(0, 1999) == 0);
        end
        btn_feed = 1'b0; btn_play = 1'b0; btn_sleep = 1'b0; reset = 1'b0;
        waitCycles(3);

        @(negedge clk);
        total++;
        if (face_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL face_change_missing got pending=%0d exp 0", face_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
